div_sqrt_issue_ctrl: RTL and testbench
======================================

DIV_SQRT_ISSUE_CTRL -- requirements
Module: div_sqrt_issue_ctrl

Interface
REQ-001 SHALL have parameter Precision_ctl_Enable_S, default 1; 0 forces Precision_ctl_SO to all-ones (full precision).
REQ-002 SHALL have ports Clk_CI in 1 (sole clock); Rst_RBI in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have upstream request ports:
- In_valid_SI in 1
- In_ready_SO out 1
- In_sqrt_SI in 1 (0 = div, 1 = sqrt)
- In_op_a_DI in C_DIV_OP
- In_op_b_DI in C_DIV_OP
- In_rm_SI in C_DIV_RM
- In_pc_SI in C_DIV_PC
REQ-004 SHALL have unit-side ports:
- Div_start_SO out 1
- Sqrt_start_SO out 1
- Operand_a_DO out C_DIV_OP
- Operand_b_DO out C_DIV_OP
- RM_SO out C_DIV_RM
- Precision_ctl_SO out C_DIV_PC
- Ready_SI in 1
- Done_SI in 1
- Result_DI in 32
- Exp_OF_SI in 1, Exp_UF_SI in 1, Div_zero_SI in 1
REQ-005 SHALL have downstream ports:
- Out_valid_SO out 1
- Out_ready_SI in 1
- Out_result_DO out 32
- Out_flags_DO out 3 ({OF,UF,DZ})

Function
REQ-006 SHALL implement FSM IDLE, ISSUE, WAIT, HOLD.
REQ-007 SHALL drive In_ready_SO = (state==IDLE) | (state==HOLD & Out_ready_SI).
REQ-008 SHALL latch sqrt, op_a, op_b, rm and pc on accept (In_valid_SI & In_ready_SO), then go to ISSUE.
REQ-009 SHALL, in ISSUE with Ready_SI=1, pulse exactly one of Div_start_SO/Sqrt_start_SO for one cycle and go to WAIT; with Ready_SI=0 it SHALL stay in ISSUE with both starts low.
REQ-010 SHALL drive Operand_a/b_DO, RM_SO and Precision_ctl_SO from the latched registers, stable from ISSUE until Done_SI.
REQ-011 SHALL forward op_b unchanged for sqrt; the unit ignores it.
REQ-012 SHALL, in WAIT on Done_SI=1, capture Result_DI and flags into the output register, set Out_valid_SO and go to HOLD.
REQ-013 SHALL, in HOLD, keep Out_valid_SO and the output data stable until Out_ready_SI=1.
- Out_ready_SI=1 alone: go to IDLE.
- Out_ready_SI=1 and a same-cycle accept: go to ISSUE.
REQ-014 SHALL ignore Done_SI outside WAIT, with no state or output change.
REQ-015 SHALL have a minimum latency of accept at T, start at T+1, Out_valid_SO at Tdone+1.
REQ-016 SHALL keep exactly one operation in flight at a time.

Reset
REQ-017 SHALL, on Rst_RBI=0, asynchronously enter IDLE and clear all registers.
- Outputs at reset: Out_valid_SO=0, starts=0, data outputs=0, In_ready_SO=1.
REQ-018 SHALL, when reset occurs mid-operation, abandon the operation and drop any held result; the unit is reset by the same net.

Configuration
REQ-019 SHALL, with macro DIV_SQRT_TAG_EN defined, add In_tag_DI in C_DIV_TAG and Out_tag_DO out C_DIV_TAG.
- The tag is latched on accept and is valid with Out_valid_SO.
- Without the macro these ports and registers SHALL be absent, with identical timing.

Structure
REQ-020 SHALL place C_DIV_TAG and the FSM state enum typedef in package fpu_defs_div_sqrt_tp, alongside C_DIV_OP, C_DIV_RM and C_DIV_PC.
REQ-021 SHALL be a single module with no sub-modules; it instantiates beside div_sqrt_top_tp at the same hierarchy level.

Verification
REQ-022 SHALL cover the following directed scenarios:
- Div 0x40400000 / 0x3F800000, Ready_SI=1: Div_start_SO pulses at T+1; model Done returns 0x40400000; Out_valid_SO=1, flags=000.
- Sqrt 0x40800000 with Ready_SI held 0 for 5 cycles: stays in ISSUE; single Sqrt_start_SO pulse on the cycle Ready_SI rises; result 0x40000000.
- Out_ready_SI=0 for 10 cycles in HOLD: result stable, In_ready_SO=0; Out_ready_SI=1 with In_valid_SI=1: back-to-back accept, next start one cycle later.
- Spurious Done_SI in IDLE: no Out_valid_SO; Div_zero_SI=1 with result 0x7F800000: Out_flags_DO=001.
- Rst_RBI low during WAIT: Out_valid_SO=0 and IDLE immediately; after reset a new request issues normally.
- With DIV_SQRT_TAG_EN, tag 0x5 is returned with its result; Precision_ctl_Enable_S=0 gives Precision_ctl_SO all-ones.

Source files
------------

// File: rtl/div_sqrt_issue_ctrl_pkg.sv
// Shared widths, request record and FSM state type for the div/sqrt issue controller.
// Optional result tagging (DIV_SQRT_TAG_EN) uses C_DIV_TAG from here.
package fpu_defs_div_sqrt_tp;

   localparam int C_DIV_OP    = 32;
   localparam int C_DIV_RM    = 3;
   localparam int C_DIV_PC    = 6;
   localparam int C_DIV_TAG   = 4;
   localparam int C_DIV_FLAGS = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } div_sqrt_state_e;

   typedef struct packed {
      logic                sqrt;
      logic [C_DIV_OP-1:0] op_a;
      logic [C_DIV_OP-1:0] op_b;
      logic [C_DIV_RM-1:0] rm;
      logic [C_DIV_PC-1:0] pc;
   } div_req_t;

   // Downstream flag ordering is {overflow, underflow, divide-by-zero}.
   function automatic logic [C_DIV_FLAGS-1:0] pack_flags(input logic of, input logic uf, input logic dz);
      return {of, uf, dz};
   endfunction

endpackage

// File: rtl/div_sqrt_issue_ctrl.sv
// Issue controller in front of div_sqrt_top_tp: accepts one request, starts the unit, holds the result.
// Define DIV_SQRT_TAG_EN to carry a request tag through to the result.
module div_sqrt_issue_ctrl
   import fpu_defs_div_sqrt_tp::*;
#(
   parameter bit Precision_ctl_Enable_S = 1'b1
) (
   input  logic                   Clk_CI,
   input  logic                   Rst_RBI,
   input  logic                   In_valid_SI,
   output logic                   In_ready_SO,
   input  logic                   In_sqrt_SI,
   input  logic [C_DIV_OP-1:0]    In_op_a_DI,
   input  logic [C_DIV_OP-1:0]    In_op_b_DI,
   input  logic [C_DIV_RM-1:0]    In_rm_SI,
   input  logic [C_DIV_PC-1:0]    In_pc_SI,
`ifdef DIV_SQRT_TAG_EN
   input  logic [C_DIV_TAG-1:0]   In_tag_DI,
   output logic [C_DIV_TAG-1:0]   Out_tag_DO,
`endif
   output logic                   Div_start_SO,
   output logic                   Sqrt_start_SO,
   output logic [C_DIV_OP-1:0]    Operand_a_DO,
   output logic [C_DIV_OP-1:0]    Operand_b_DO,
   output logic [C_DIV_RM-1:0]    RM_SO,
   output logic [C_DIV_PC-1:0]    Precision_ctl_SO,
   input  logic                   Ready_SI,
   input  logic                   Done_SI,
   input  logic [31:0]            Result_DI,
   input  logic                   Exp_OF_SI,
   input  logic                   Exp_UF_SI,
   input  logic                   Div_zero_SI,
   output logic                   Out_valid_SO,
   input  logic                   Out_ready_SI,
   output logic [31:0]            Out_result_DO,
   output logic [C_DIV_FLAGS-1:0] Out_flags_DO
);

   div_sqrt_state_e        state_r;
   div_req_t               req_r;
   div_req_t               in_req_s;
   logic [31:0]            result_r;
   logic [C_DIV_FLAGS-1:0] flags_r;
   logic                   out_valid_r;
   logic                   in_ready_s;
   logic                   issue_s;
`ifdef DIV_SQRT_TAG_EN
   logic [C_DIV_TAG-1:0]   tag_r;
`endif

   assign in_req_s = '{sqrt: In_sqrt_SI, op_a: In_op_a_DI, op_b: In_op_b_DI,
                       rm: In_rm_SI, pc: In_pc_SI};

   // Upstream ready: free when idle, or when the held result leaves this cycle.
   always_comb begin
      in_ready_s = 1'b0;
      if (state_r == IDLE) begin
         in_ready_s = 1'b1;
      end else if (state_r == HOLD) begin
         in_ready_s = Out_ready_SI;
      end else begin
         in_ready_s = 1'b0;
      end
   end

   assign issue_s = (state_r == ISSUE) & Ready_SI;

   // Control FSM together with the request, result and tag registers it owns.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_r     <= IDLE;
         req_r       <= '0;
         result_r    <= 32'd0;
         flags_r     <= {C_DIV_FLAGS{1'b0}};
         out_valid_r <= 1'b0;
`ifdef DIV_SQRT_TAG_EN
         tag_r       <= {C_DIV_TAG{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (In_valid_SI) begin
                  req_r   <= in_req_s;
`ifdef DIV_SQRT_TAG_EN
                  tag_r   <= In_tag_DI;
`endif
                  state_r <= ISSUE;
               end
            end
            ISSUE: begin
               if (Ready_SI) begin
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               if (Done_SI) begin
                  result_r    <= Result_DI;
                  flags_r     <= pack_flags(Exp_OF_SI, Exp_UF_SI, Div_zero_SI);
                  out_valid_r <= 1'b1;
                  state_r     <= HOLD;
               end
            end
            HOLD: begin
               // A new request may enter in the same cycle the old result is taken.
               if (Out_ready_SI) begin
                  out_valid_r <= 1'b0;
                  if (In_valid_SI) begin
                     req_r   <= in_req_s;
`ifdef DIV_SQRT_TAG_EN
                     tag_r   <= In_tag_DI;
`endif
                     state_r <= ISSUE;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign In_ready_SO      = in_ready_s;
   assign Div_start_SO     = issue_s & ~req_r.sqrt;
   assign Sqrt_start_SO    = issue_s &  req_r.sqrt;
   assign Operand_a_DO     = req_r.op_a;
   assign Operand_b_DO     = req_r.op_b;
   assign RM_SO            = req_r.rm;
   assign Precision_ctl_SO = Precision_ctl_Enable_S ? req_r.pc : {C_DIV_PC{1'b1}};
   assign Out_valid_SO     = out_valid_r;
   assign Out_result_DO    = result_r;
   assign Out_flags_DO     = flags_r;
`ifdef DIV_SQRT_TAG_EN
   assign Out_tag_DO       = tag_r;
`endif

endmodule

// File: tb/tb_div_sqrt_issue_ctrl.sv
// Scoreboard bench for div_sqrt_issue_ctrl with a behavioural div/sqrt unit model.
// Tag checks are active when DIV_SQRT_TAG_EN is defined.
module tb_div_sqrt_issue_ctrl;
   import fpu_defs_div_sqrt_tp::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic                   in_valid = 1'b0, in_sqrt = 1'b0;
   logic [C_DIV_OP-1:0]    in_a = '0, in_b = '0;
   logic [C_DIV_RM-1:0]    in_rm = '0;
   logic [C_DIV_PC-1:0]    in_pc = '0;
   logic [C_DIV_TAG-1:0]   in_tag = '0;
   logic                   in_ready, div_start, sqrt_start, out_valid;
   logic [C_DIV_OP-1:0]    op_a, op_b;
   logic [C_DIV_RM-1:0]    rm_o;
   logic [C_DIV_PC-1:0]    pc_o;
   logic [31:0]            out_result;
   logic [C_DIV_FLAGS-1:0] out_flags;
   logic [C_DIV_TAG-1:0]   out_tag;
   logic                   in_ready2, div_start2, sqrt_start2, out_valid2;
   logic [C_DIV_OP-1:0]    op_a2, op_b2;
   logic [C_DIV_RM-1:0]    rm_o2;
   logic [C_DIV_PC-1:0]    pc_o2;
   logic [31:0]            out_result2;
   logic [C_DIV_FLAGS-1:0] out_flags2;
   logic [C_DIV_TAG-1:0]   out_tag2;

   // bench knobs
   logic ready_block = 1'b0, rb_rand = 1'b0, rb_bit = 1'b0;
   logic force_low = 1'b0, sink_rand = 1'b0, sink_bit = 1'b1;
   logic spur_done = 1'b0;
   logic [31:0] spur_res = 32'd0;
   int lat_lo = 0, lat_hi = 4;

   // unit model state
   logic u_busy, u_done;
   logic [3:0] u_cnt;
   logic [31:0] u_res;
   logic [2:0] u_flg;

   wire ready_si  = !u_busy && !u_done && !ready_block && !(rb_rand && rb_bit);
   wire done_si   = u_done | spur_done;
   wire [31:0] result_di = spur_done ? spur_res : u_res;
   wire out_ready = force_low ? 1'b0 : (sink_rand ? sink_bit : 1'b1);

   div_sqrt_issue_ctrl dut (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .In_valid_SI(in_valid), .In_ready_SO(in_ready), .In_sqrt_SI(in_sqrt),
      .In_op_a_DI(in_a), .In_op_b_DI(in_b), .In_rm_SI(in_rm), .In_pc_SI(in_pc),
`ifdef DIV_SQRT_TAG_EN
      .In_tag_DI(in_tag), .Out_tag_DO(out_tag),
`endif
      .Div_start_SO(div_start), .Sqrt_start_SO(sqrt_start),
      .Operand_a_DO(op_a), .Operand_b_DO(op_b), .RM_SO(rm_o), .Precision_ctl_SO(pc_o),
      .Ready_SI(ready_si), .Done_SI(done_si), .Result_DI(result_di),
      .Exp_OF_SI(u_flg[2]), .Exp_UF_SI(u_flg[1]), .Div_zero_SI(u_flg[0]),
      .Out_valid_SO(out_valid), .Out_ready_SI(out_ready),
      .Out_result_DO(out_result), .Out_flags_DO(out_flags)
   );

   div_sqrt_issue_ctrl #(.Precision_ctl_Enable_S(1'b0)) dut_fullprec (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .In_valid_SI(in_valid), .In_ready_SO(in_ready2), .In_sqrt_SI(in_sqrt),
      .In_op_a_DI(in_a), .In_op_b_DI(in_b), .In_rm_SI(in_rm), .In_pc_SI(in_pc),
`ifdef DIV_SQRT_TAG_EN
      .In_tag_DI(in_tag), .Out_tag_DO(out_tag2),
`endif
      .Div_start_SO(div_start2), .Sqrt_start_SO(sqrt_start2),
      .Operand_a_DO(op_a2), .Operand_b_DO(op_b2), .RM_SO(rm_o2), .Precision_ctl_SO(pc_o2),
      .Ready_SI(ready_si), .Done_SI(done_si), .Result_DI(result_di),
      .Exp_OF_SI(u_flg[2]), .Exp_UF_SI(u_flg[1]), .Div_zero_SI(u_flg[0]),
      .Out_valid_SO(out_valid2), .Out_ready_SI(out_ready),
      .Out_result_DO(out_result2), .Out_flags_DO(out_flags2)
   );

   // Behaviour of the arithmetic unit: {of, uf, dz, result} for a request.
   function automatic logic [34:0] ref_unit(input logic sq, input logic [31:0] a, input logic [31:0] b,
                                            input logic [C_DIV_RM-1:0] rm, input logic [C_DIV_PC-1:0] pc);
      logic of, uf, dz;
      logic [31:0] r;
      dz = !sq && (b[30:0] == 31'd0);
      of = !sq && !dz && (a[30:23] == 8'hFE);
      uf = !sq && !dz && (a[30:23] == 8'h01);
      if (dz)      r = 32'h7F800000;
      else if (sq) r = (a == 32'h40800000) ? 32'h40000000 : (((a >> 1) + 32'h1FC00000) ^ {26'd0, pc});
      else         r = (b == 32'h3F800000) ? a : ((a ^ {b[15:0], b[31:16]}) + {29'd0, rm});
      return {of, uf, dz, r};
   endfunction

   // Unit model: samples a start while ready, answers after a random latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_busy <= 1'b0; u_done <= 1'b0; u_cnt <= 4'd0; u_res <= 32'd0; u_flg <= 3'd0;
      end else begin
         u_done <= 1'b0;
         if (u_busy) begin
            if (u_cnt == 4'd0) begin u_busy <= 1'b0; u_done <= 1'b1; end
            else u_cnt <= u_cnt - 4'd1;
         end else if (ready_si && (div_start || sqrt_start)) begin
            {u_flg, u_res} <= ref_unit(sqrt_start, op_a, op_b, rm_o, pc_o);
            u_busy <= 1'b1;
            u_cnt  <= 4'($urandom_range(lat_hi, lat_lo));
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      sink_bit = 1'($urandom_range(1, 0));
      rb_bit   = ($urandom_range(3, 0) == 0);
   end

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flg;
      logic [C_DIV_TAG-1:0] tag;
   } exp_t;
   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pops, hold stability and start-pulse rules.
   initial begin
      logic prev_v, prev_r, prev_start;
      logic [31:0] prev_res;
      logic [2:0] prev_flg;
      exp_t e;
      prev_v = 1'b0; prev_r = 1'b0; prev_start = 1'b0; prev_res = 32'd0; prev_flg = 3'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0; prev_start = 1'b0;
         end else begin
            if (div_start || sqrt_start) begin
               chk("start_with_ready", ready_si, 1);
               chk("start_onehot", div_start & sqrt_start, 0);
               chk("start_one_cycle", prev_start, 0);
            end
            prev_start = div_start | sqrt_start;
            if (prev_v && !prev_r) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_result", out_result, prev_res);
               chk("hold_flags", out_flags, prev_flg);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", out_result, e.res);
                  chk("flags", out_flags, e.flg);
`ifdef DIV_SQRT_TAG_EN
                  chk("tag", out_tag, e.tag);
`endif
               end
            end
            prev_v = out_valid; prev_r = out_ready; prev_res = out_result; prev_flg = out_flags;
         end
      end
   end

   // Drive a request (call away from the clock edge); returns just after the accepting edge.
   task automatic send(input logic sq, input logic [31:0] a, input logic [31:0] b,
                       input logic [C_DIV_RM-1:0] rm, input logic [C_DIV_PC-1:0] pc,
                       input logic [C_DIV_TAG-1:0] tag);
      logic [34:0] r;
      int n;
      in_valid = 1'b1; in_sqrt = sq; in_a = a; in_b = b; in_rm = rm; in_pc = pc; in_tag = tag;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      chk("accept_seen", in_ready, 1);
      r = ref_unit(sq, a, b, rm, pc);
      exp_q.push_back('{res: r[31:0], flg: r[34:32], tag: tag});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_valid) && n < bound) begin @(negedge clk); n++; end
      chk("drain", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_starts", {div_start, sqrt_start}, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
      chk("rst_rm_pc", {rm_o, pc_o}, 0);
      chk("rst_result", {out_result, out_flags}, 0);
      chk("rst_prec_full", pc_o2, {C_DIV_PC{1'b1}});
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // div 3.0 / 1.0 with tag 5
      send(1'b0, 32'h40400000, 32'h3F800000, 3'd0, 6'h2A, 4'h5);
      @(negedge clk);
      chk("div_start_t1", div_start, 1);
      chk("sqrt_start_t1", sqrt_start, 0);
      chk("op_a_out", op_a, 32'h40400000);
      chk("op_b_out", op_b, 32'h3F800000);
      chk("prec_ctl", pc_o, 6'h2A);
      chk("prec_ctl_full", pc_o2, 6'h3F);
      n = 0;
      while (!done_si && n < 50) begin @(negedge clk); n++; end
      chk("done_seen", done_si, 1);
      chk("valid_at_done", out_valid, 0);
      @(negedge clk);
      chk("valid_tdone1", out_valid, 1);
      wait_idle(50);

      // sqrt 4.0 with unit not ready for 5 cycles
      ready_block = 1'b1;
      send(1'b1, 32'h40800000, 32'hDEADBEEF, 3'd1, 6'h11, 4'h3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("start_blocked", {div_start, sqrt_start}, 0);
      end
      @(posedge clk); #1 ready_block = 1'b0;
      @(negedge clk);
      chk("sqrt_start", sqrt_start, 1);
      chk("sqrt_no_div", div_start, 0);
      chk("op_b_forwarded", op_b, 32'hDEADBEEF);
      @(negedge clk);
      chk("sqrt_single_pulse", sqrt_start, 0);
      wait_idle(50);

      // result held 10 cycles, then back-to-back accept
      force_low = 1'b1;
      send(1'b0, 32'h41200000, 32'h40000000, 3'd2, 6'h05, 4'h9);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      chk("hold_reached", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_in_ready_low", in_ready, 0);
      end
      @(posedge clk); #1 force_low = 1'b0;
      send(1'b1, 32'h42000000, 32'h0, 3'd3, 6'h3C, 4'hA);
      @(negedge clk);
      chk("b2b_start", sqrt_start, 1);
      wait_idle(50);

      // spurious done while idle, then divide by zero
      spur_res = 32'h12345678; spur_done = 1'b1;
      @(posedge clk); #1 spur_done = 1'b0;
      @(negedge clk);
      chk("spur_no_valid", out_valid, 0);
      chk("spur_in_ready", in_ready, 1);
      @(posedge clk); #1;
      send(1'b0, 32'h3F800000, 32'h00000000, 3'd0, 6'h01, 4'h1);
      wait_idle(50);

      // reset while waiting on the unit
      lat_lo = 10; lat_hi = 10;
      send(1'b0, 32'h40A00000, 32'h40400000, 3'd1, 6'h07, 4'h2);
      n = 0;
      @(negedge clk);
      while (!div_start && n < 20) begin @(negedge clk); n++; end
      chk("rst_case_start", div_start, 1);
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_op_a", op_a, 0);
      exp_q.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      lat_lo = 0; lat_hi = 4;
      @(posedge clk); #1;
      send(1'b0, 32'h40C00000, 32'h3F800000, 3'd0, 6'h10, 4'h6);
      wait_idle(50);

      // randomized traffic with random unit latency and back-pressure
      sink_rand = 1'b1; rb_rand = 1'b1;
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a, b;
         logic sq;
         a = $urandom; b = $urandom;
         sq = 1'($urandom_range(1, 0));
         if ($urandom_range(7, 0) == 0) a[30:23] = 8'hFE;
         if ($urandom_range(7, 0) == 1) a[30:23] = 8'h01;
         if ($urandom_range(7, 0) == 2) b[30:0] = 31'd0;
         repeat ($urandom_range(2, 0)) @(posedge clk);
         #1;
         send(sq, a, b, 3'($urandom), 6'($urandom), 4'($urandom));
      end
      wait_idle(500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
